// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with start bit, 8 data bits sent LSB first, and a stop bit.
// Define UART_TX_PARITY_EN to add an even parity bit after bit 7.
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx_out,
    output logic       ready
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_d, ready_d, bit_end, accept;
    assign bit_end = baud_q == LAST;
    // A new byte may also be taken on the edge that ends the stop bit.
    assign accept = start && (state_q == IDLE || (state_q == STOP && bit_end));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_out  <= 1'b1;
            ready   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_out  <= tx_d;
            ready   <= ready_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = accept ? START : IDLE;
            START:  state_d = bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:   state_d = (bit_end && bit_q == 3'd7) ? PARITY : DATA;
            PARITY: state_d = bit_end ? STOP : PARITY;
`else
            DATA:   state_d = (bit_end && bit_q == 3'd7) ? STOP : DATA;
`endif
            STOP:   state_d = accept ? START : bit_end ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        baud_d  = (state_q == IDLE || accept || bit_end) ? 16'd0 : baud_q + 16'd1;
        bit_d   = state_q != DATA ? 3'd0 : bit_end ? bit_q + 3'd1 : bit_q;
        shift_d = accept ? data : shift_q;
        tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_q[bit_d] : 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_d == PARITY) tx_d = ^shift_q;
`endif
        ready_d = state_d == IDLE;
    end
endmodule
